user_obi_copy_mgr: RTL and testbench



---
 rtl/user_pkg.sv | 92 +++++++++
 rtl/user_obi_copy_regs.sv | 102 ++++++++++
 rtl/user_obi_copy_mgr.sv | 150 +++++++++++++++
 tb/tb_user_obi_copy_mgr.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_pkg.sv
// Shared definitions for the user-domain copy engine: OBI structs, register map,
// control/status bit positions, FSM states and the subordinate demux rule.
package user_pkg;

    localparam int unsigned SbrAidWidth = 4;
    localparam int unsigned MgrAidWidth = 1;

    typedef struct packed {
        logic                   req;
        logic [31:0]            addr;
        logic                   we;
        logic [3:0]             be;
        logic [31:0]            wdata;
        logic [SbrAidWidth-1:0] aid;
    } sbr_obi_req_t;

    typedef struct packed {
        logic                   gnt;
        logic                   rvalid;
        logic [31:0]            rdata;
        logic [SbrAidWidth-1:0] rid;
        logic                   err;
    } sbr_obi_rsp_t;

    typedef struct packed {
        logic                   req;
        logic [31:0]            addr;
        logic                   we;
        logic [3:0]             be;
        logic [31:0]            wdata;
        logic [MgrAidWidth-1:0] aid;
    } mgr_obi_req_t;

    typedef struct packed {
        logic                   gnt;
        logic                   rvalid;
        logic [31:0]            rdata;
        logic [MgrAidWidth-1:0] rid;
        logic                   err;
    } mgr_obi_rsp_t;

    // Register byte offsets inside the 32-byte window decoded from addr[4:2]
    localparam logic [4:0] CopySrcOffs    = 5'h00;
    localparam logic [4:0] CopyDstOffs    = 5'h04;
    localparam logic [4:0] CopyLenOffs    = 5'h08;
    localparam logic [4:0] CopyCtrlOffs   = 5'h0C;
    localparam logic [4:0] CopyStatusOffs = 5'h10;

    localparam int unsigned CopyCtrlStartBit     = 0;
    localparam int unsigned CopyCtrlClrBit       = 1;
    localparam int unsigned CopyStatusBusyBit    = 0;
    localparam int unsigned CopyStatusDoneBit    = 1;
    localparam int unsigned CopyStatusErrBit     = 2;
    localparam int unsigned CopyStatusRemainLsb  = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } copy_state_e;

    // Subordinate demux entry for the copy engine's register window
    localparam int unsigned UserCopyMgr           = 0;
    localparam logic [31:0] UserCopyMgrAddrOffset = 32'h2000_1000;
    localparam logic [31:0] UserCopyMgrAddrRange  = 32'h0000_1000;

    typedef struct packed {
        int unsigned idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam addr_map_rule_t UserCopyMgrRule = '{
        idx:        UserCopyMgr,
        start_addr: UserCopyMgrAddrOffset,
        end_addr:   UserCopyMgrAddrOffset + UserCopyMgrAddrRange
    };

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/user_obi_copy_regs.sv
// OBI subordinate register file for the copy engine: SRC/DST/LEN storage,
// START/CLR pulse decode and a one-cycle registered response path.
module user_obi_copy_regs #(
    parameter int unsigned LenWidth = 16,
    parameter type sbr_obi_req_t = user_pkg::sbr_obi_req_t,
    parameter type sbr_obi_rsp_t = user_pkg::sbr_obi_rsp_t
) (
    input  logic                clk,
    input  logic                rst,
    input  sbr_obi_req_t        sbr_req,
    output sbr_obi_rsp_t        sbr_rsp,
    input  logic                busy,
    input  logic                done,
    input  logic                err,
    input  logic [LenWidth-1:0] remaining,
    output logic [31:0]         src,
    output logic [31:0]         dst,
    output logic [LenWidth-1:0] len,
    output logic                start,
    output logic                clr
);
    import user_pkg::*;

    logic [4:0]  offs;
    logic        wr;
    logic [31:0] rdata_d;
    logic [31:0] status;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [$bits(sbr_req.aid)-1:0] rid_q;
    logic        unused_addr;

    assign offs = {sbr_req.addr[4:2], 2'b00};
    assign wr   = sbr_req.req & sbr_req.we;
    assign unused_addr = ^{sbr_req.addr[31:5], sbr_req.addr[1:0]};

    // Control pulses are dropped entirely while a copy is running
    assign start = wr && (offs == CopyCtrlOffs) && sbr_req.be[0]
                   && sbr_req.wdata[CopyCtrlStartBit] && !busy;
    assign clr   = wr && (offs == CopyCtrlOffs) && sbr_req.be[0]
                   && sbr_req.wdata[CopyCtrlClrBit] && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src <= '0;
            dst <= '0;
            len <= '0;
        end else if (wr && !busy) begin
            case (offs)
                CopySrcOffs: src <= apply_be(src, sbr_req.wdata, sbr_req.be) & 32'hFFFF_FFFC;
                CopyDstOffs: dst <= apply_be(dst, sbr_req.wdata, sbr_req.be) & 32'hFFFF_FFFC;
                CopyLenOffs: len <= LenWidth'(apply_be(32'(len), sbr_req.wdata, sbr_req.be));
                default: ;
            endcase
        end
    end

    always_comb begin
        status = '0;
        status[CopyStatusBusyBit] = busy;
        status[CopyStatusDoneBit] = done;
        status[CopyStatusErrBit]  = err;
        status[31:CopyStatusRemainLsb] = 16'(remaining);
    end

    always_comb begin
        rdata_d = '0;
        if (!sbr_req.we) begin
            case (offs)
                CopySrcOffs:    rdata_d = src;
                CopyDstOffs:    rdata_d = dst;
                CopyLenOffs:    rdata_d = 32'(len);
                CopyStatusOffs: rdata_d = status;
                default:        rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= sbr_req.req;
            if (sbr_req.req) begin
                rdata_q <= rdata_d;
                rid_q   <= sbr_req.aid;
            end
        end
    end

    always_comb begin
        sbr_rsp        = '0;
        sbr_rsp.gnt    = 1'b1;
        sbr_rsp.rvalid = rvalid_q;
        sbr_rsp.rdata  = rdata_q;
        sbr_rsp.rid    = rid_q;
        sbr_rsp.err    = 1'b0;
    end

endmodule

// File: rtl/user_obi_copy_mgr.sv
// User-domain OBI copy engine: moves LEN words from SRC to DST with one
// read-then-write pair at a time on the manager port; irq on done or error.
module user_obi_copy_mgr #(
    parameter int unsigned LenWidth = 16,
    parameter type sbr_obi_req_t = user_pkg::sbr_obi_req_t,
    parameter type sbr_obi_rsp_t = user_pkg::sbr_obi_rsp_t,
    parameter type mgr_obi_req_t = user_pkg::mgr_obi_req_t,
    parameter type mgr_obi_rsp_t = user_pkg::mgr_obi_rsp_t
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  sbr_obi_req_t sbr_obi_req_i,
    output sbr_obi_rsp_t sbr_obi_rsp_o,
    output mgr_obi_req_t mgr_obi_req_o,
    input  mgr_obi_rsp_t mgr_obi_rsp_i,
    output logic         irq_o
);
    import user_pkg::*;

    copy_state_e         state;
    logic [31:0]         src_ptr;
    logic [31:0]         dst_ptr;
    logic [LenWidth-1:0] remaining;
    logic                done;
    logic                err;
    mgr_obi_req_t        req;

    logic [31:0]         src_cfg;
    logic [31:0]         dst_cfg;
    logic [LenWidth-1:0] len_cfg;
    logic                start;
    logic                clr;
    logic                busy;
    logic                unused_rsp;

    assign busy          = (state != IDLE);
    assign irq_o         = done | err;
    assign mgr_obi_req_o = req;
    assign unused_rsp    = ^mgr_obi_rsp_i.rid;

    user_obi_copy_regs #(
        .LenWidth      (LenWidth),
        .sbr_obi_req_t (sbr_obi_req_t),
        .sbr_obi_rsp_t (sbr_obi_rsp_t)
    ) i_regs (
        .clk       (clk_i),
        .rst       (rst_i),
        .sbr_req   (sbr_obi_req_i),
        .sbr_rsp   (sbr_obi_rsp_o),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .remaining (remaining),
        .src       (src_cfg),
        .dst       (dst_cfg),
        .len       (len_cfg),
        .start     (start),
        .clr       (clr)
    );

    // Request fields are registered and only change on the state transitions
    // below, so they stay stable for as long as gnt is withheld.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            req       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done      <= 1'b0;
                        err       <= 1'b0;
                        remaining <= len_cfg;
                        if (len_cfg != '0) begin
                            state     <= RD_REQ;
                            src_ptr   <= src_cfg;
                            dst_ptr   <= dst_cfg;
                            req.req   <= 1'b1;
                            req.we    <= 1'b0;
                            req.addr  <= src_cfg;
                            req.be    <= 4'hF;
                            req.aid   <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (clr) begin
                        done <= 1'b0;
                        err  <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (mgr_obi_rsp_i.gnt) begin
                        req.req <= 1'b0;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mgr_obi_rsp_i.rvalid) begin
                        if (mgr_obi_rsp_i.err) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            req.req   <= 1'b1;
                            req.we    <= 1'b1;
                            req.addr  <= dst_ptr;
                            req.wdata <= mgr_obi_rsp_i.rdata;
                            req.be    <= 4'hF;
                            state     <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (mgr_obi_rsp_i.gnt) begin
                        req.req <= 1'b0;
                        state   <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (mgr_obi_rsp_i.rvalid) begin
                        if (mgr_obi_rsp_i.err) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            src_ptr   <= src_ptr + 32'd4;
                            dst_ptr   <= dst_ptr + 32'd4;
                            remaining <= remaining - LenWidth'(1);
                            if (remaining == LenWidth'(1)) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                req.req  <= 1'b1;
                                req.we   <= 1'b0;
                                req.addr <= src_ptr + 32'd4;
                                req.be   <= 4'hF;
                                state    <= RD_REQ;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_user_obi_copy_mgr.sv
// Directed bench for user_obi_copy_mgr with a small manager-side memory model.
module tb_user_obi_copy_mgr;
    import user_pkg::*;

    localparam logic [31:0] Base = UserCopyMgrAddrOffset;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sbr_obi_req_t sbr_req;
    sbr_obi_rsp_t sbr_rsp;
    mgr_obi_req_t mgr_req;
    mgr_obi_rsp_t mgr_rsp;
    logic         irq;

    user_obi_copy_mgr dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sbr_obi_req_i (sbr_req),
        .sbr_obi_rsp_o (sbr_rsp),
        .mgr_obi_req_o (mgr_req),
        .mgr_obi_rsp_i (mgr_rsp),
        .irq_o         (irq)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory model: gnt withheld while stall_left > 0, response one cycle after gnt
    logic [31:0] mem [logic [31:0]];
    int          stall_left  = 0;
    int          err_read_at = 0;
    int          rd_count    = 0;
    int          req_cycles  = 0;
    logic        pend_valid  = 1'b0;
    logic        pend_err    = 1'b0;
    logic [31:0] pend_rdata  = '0;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic        op_q [$];
    logic [36:0] stall_q [$];

    always_comb begin
        mgr_rsp        = '0;
        mgr_rsp.gnt    = mgr_req.req && (stall_left == 0);
        mgr_rsp.rvalid = pend_valid;
        mgr_rsp.rdata  = pend_rdata;
        mgr_rsp.err    = pend_err;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_err   <= 1'b0;
            pend_rdata <= '0;
        end else begin
            pend_valid <= 1'b0;
            pend_err   <= 1'b0;
            if (mgr_req.req) begin
                req_cycles <= req_cycles + 1;
                if (stall_left != 0) begin
                    stall_left <= stall_left - 1;
                    stall_q.push_back({mgr_req.addr, mgr_req.we, mgr_req.be});
                end else begin
                    pend_valid <= 1'b1;
                    op_q.push_back(mgr_req.we);
                    if (mgr_req.we) begin
                        wr_addr_q.push_back(mgr_req.addr);
                        wr_data_q.push_back(mgr_req.wdata);
                        pend_rdata <= '0;
                    end else begin
                        rd_count   <= rd_count + 1;
                        pend_rdata <= mem.exists(mgr_req.addr) ? mem[mgr_req.addr] : 32'h0;
                        pend_err   <= ((rd_count + 1) == err_read_at);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [4:0] offs, input logic [31:0] data);
        @(negedge clk);
        sbr_req       = '0;
        sbr_req.req   = 1'b1;
        sbr_req.we    = 1'b1;
        sbr_req.addr  = Base + 32'(offs);
        sbr_req.be    = 4'hF;
        sbr_req.wdata = data;
        sbr_req.aid   = 4'h3;
        @(negedge clk);
        sbr_req = '0;
    endtask

    task automatic expect_reg(input string tag, input logic [4:0] offs, input logic [31:0] exp);
        @(negedge clk);
        sbr_req      = '0;
        sbr_req.req  = 1'b1;
        sbr_req.addr = Base + 32'(offs);
        sbr_req.be   = 4'hF;
        sbr_req.aid  = 4'h5;
        @(negedge clk);
        sbr_req = '0;
        check({tag, "_rvalid"}, 32'(sbr_rsp.rvalid), 32'd1);
        check({tag, "_rid"}, 32'(sbr_rsp.rid), 32'h5);
        check(tag, sbr_rsp.rdata, exp);
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(irq), 32'd1);
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        op_q.delete();
        stall_q.delete();
    endtask

    int unsigned ops;
    int          snap;
    int          n;

    initial begin
        sbr_req = '0;
        repeat (3) @(negedge clk);
        check("rst_mgr_req", 32'(mgr_req.req), 32'd0);
        check("rst_mgr_addr", mgr_req.addr, 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_sbr_rvalid", 32'(sbr_rsp.rvalid), 32'd0);
        rst = 1'b0;
        expect_reg("rst_src", CopySrcOffs, 32'h0);
        expect_reg("rst_status", CopyStatusOffs, 32'h0);

        // Three-word copy
        mem[32'h1000_0000] = 32'hA;
        mem[32'h1000_0004] = 32'hB;
        mem[32'h1000_0008] = 32'hC;
        clear_logs();
        reg_write(CopySrcOffs, 32'h1000_0000);
        reg_write(CopyDstOffs, 32'h1000_0100);
        reg_write(CopyLenOffs, 32'd3);
        expect_reg("len_rb", CopyLenOffs, 32'd3);
        reg_write(CopyCtrlOffs, 32'h1);
        wait_irq("copy3_irq");
        check("copy3_nwr", wr_addr_q.size(), 32'd3);
        check("copy3_wa0", wr_addr_q[0], 32'h1000_0100);
        check("copy3_wa1", wr_addr_q[1], 32'h1000_0104);
        check("copy3_wa2", wr_addr_q[2], 32'h1000_0108);
        check("copy3_wd0", wr_data_q[0], 32'hA);
        check("copy3_wd1", wr_data_q[1], 32'hB);
        check("copy3_wd2", wr_data_q[2], 32'hC);
        ops = 0;
        foreach (op_q[i]) ops = (ops << 1) | 32'(op_q[i]);
        check("copy3_op_order", ops, 32'h15);
        check("copy3_nrd", rd_count, 32'd3);
        expect_reg("copy3_status", CopyStatusOffs, 32'h0000_0002);

        // Zero-length start
        reg_write(CopyCtrlOffs, 32'h2);
        check("clr_irq", 32'(irq), 32'd0);
        snap = req_cycles;
        reg_write(CopyLenOffs, 32'd0);
        reg_write(CopyCtrlOffs, 32'h1);
        check("len0_irq", 32'(irq), 32'd1);
        repeat (10) @(negedge clk);
        check("len0_no_req", req_cycles, snap);
        expect_reg("len0_status", CopyStatusOffs, 32'h0000_0002);

        // Read stalled for 5 cycles
        reg_write(CopyCtrlOffs, 32'h2);
        clear_logs();
        mem[32'h2000_0000] = 32'h1111_2222;
        reg_write(CopySrcOffs, 32'h2000_0000);
        reg_write(CopyDstOffs, 32'h2000_0040);
        reg_write(CopyLenOffs, 32'd1);
        stall_left = 5;
        reg_write(CopyCtrlOffs, 32'h1);
        wait_irq("stall_irq");
        check("stall_cnt", stall_q.size(), 32'd5);
        foreach (stall_q[i]) begin
            check("stall_addr", stall_q[i][36:5], 32'h2000_0000);
            check("stall_we_be", 32'(stall_q[i][4:0]), 32'h0F);
        end
        check("stall_wa", wr_addr_q[0], 32'h2000_0040);
        check("stall_wd", wr_data_q[0], 32'h1111_2222);
        expect_reg("stall_status", CopyStatusOffs, 32'h0000_0002);

        // Error on second read
        reg_write(CopyCtrlOffs, 32'h2);
        clear_logs();
        mem[32'h3000_0000] = 32'h1;
        mem[32'h3000_0004] = 32'h2;
        err_read_at = rd_count + 2;
        reg_write(CopySrcOffs, 32'h3000_0000);
        reg_write(CopyDstOffs, 32'h3000_0100);
        reg_write(CopyLenOffs, 32'd2);
        reg_write(CopyCtrlOffs, 32'h1);
        wait_irq("err_irq");
        repeat (4) @(negedge clk);
        check("err_nwr", wr_addr_q.size(), 32'd1);
        check("err_wa0", wr_addr_q[0], 32'h3000_0100);
        expect_reg("err_status", CopyStatusOffs, 32'h0001_0004);
        err_read_at = 0;

        // Writes and START while busy are ignored
        reg_write(CopyCtrlOffs, 32'h2);
        clear_logs();
        mem[32'h4000_0000] = 32'hA0;
        mem[32'h4000_0004] = 32'hA1;
        reg_write(CopySrcOffs, 32'h4000_0000);
        reg_write(CopyDstOffs, 32'h4000_0100);
        reg_write(CopyLenOffs, 32'd2);
        stall_left = 12;
        reg_write(CopyCtrlOffs, 32'h1);
        expect_reg("busy_status", CopyStatusOffs, 32'h0002_0001);
        reg_write(CopyDstOffs, 32'hDEAD_BEEC);
        reg_write(CopyCtrlOffs, 32'h1);
        expect_reg("busy_dst_rb", CopyDstOffs, 32'h4000_0100);
        wait_irq("busy_irq");
        check("busy_nwr", wr_addr_q.size(), 32'd2);
        check("busy_wa0", wr_addr_q[0], 32'h4000_0100);
        check("busy_wa1", wr_addr_q[1], 32'h4000_0104);
        check("busy_wd1", wr_data_q[1], 32'hA1);
        reg_write(CopyCtrlOffs, 32'h2);
        check("clr_after_done_irq", 32'(irq), 32'd0);
        expect_reg("clr_status", CopyStatusOffs, 32'h0);

        // Reset during WR_REQ
        mem[32'h5000_0000] = 32'h55;
        reg_write(CopySrcOffs, 32'h5000_0000);
        reg_write(CopyDstOffs, 32'h5000_0100);
        reg_write(CopyLenOffs, 32'd1);
        reg_write(CopyCtrlOffs, 32'h1);
        n = 0;
        while (!(mgr_req.req === 1'b1 && mgr_req.we === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wr_req_reached", 32'(mgr_req.req & mgr_req.we), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_mgr_req", 32'(mgr_req.req), 32'd0);
        check("midrst_mgr_addr", mgr_req.addr, 32'h0);
        check("midrst_mgr_wdata", mgr_req.wdata, 32'h0);
        check("midrst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_reg("post_rst_src", CopySrcOffs, 32'h0);
        expect_reg("post_rst_dst", CopyDstOffs, 32'h0);
        expect_reg("post_rst_len", CopyLenOffs, 32'h0);
        expect_reg("post_rst_status", CopyStatusOffs, 32'h0);
        check("post_rst_mgr_req", 32'(mgr_req.req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
